// File: rtl/ctrl_pkg.sv
// Shared encodings for the countdown sequencing controller.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] AN_ONES  = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_BLANK = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Presets come straight from switches, so any non-BCD code saturates to 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button synchroniser followed by a rising-edge one-shot.
// Holding the button yields a single pulse; SYNC_STAGES is 2 or 3.
module btn_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw level through the synchroniser and remember the last synced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer with start/pause/load/done control and
// a two-digit multiplexed seven-segment scan (active-low anodes).
module countdown_ctrl
  import ctrl_pkg::*;
#(
  parameter int DONE_TICKS  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       scan_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  output logic [3:0] digit,
  output logic [1:0] an,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [1:0] state,
  output logic       done
);

  localparam int              DCW       = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [DCW-1:0] DONE_LAST = DCW'(DONE_TICKS - 1);

  state_t         r_state;
  logic [3:0]     r_tens;
  logic [3:0]     r_ones;
  logic           r_done;
  logic           r_blink;
  logic [DCW-1:0] r_done_cnt;
  logic           r_sel;
  logic [3:0]     r_digit;
  logic [1:0]     r_an;

  logic           w_start;
  logic           w_pause;
  logic           w_load;
  logic [3:0]     w_pre_tens;
  logic [3:0]     w_pre_ones;
  logic           w_cnt_zero;
  logic           w_last_count;

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_btn_start (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_start),
    .o_pulse(w_start)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_btn_pause (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_pause),
    .o_pulse(w_pause)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_btn_load (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_load),
    .o_pulse(w_load)
  );

  assign w_pre_tens   = clamp_bcd(preset_tens);
  assign w_pre_ones   = clamp_bcd(preset_ones);
  assign w_cnt_zero   = (r_tens == 4'd0) && (r_ones == 4'd0);
  // Treating 00 like 01 in RUN keeps the counter from ever wrapping below zero.
  assign w_last_count = (r_tens == 4'd0) && (r_ones <= 4'd1);

  // Control FSM: count, state, done flag and DONE-phase blink timer.
  // Buttons that a state ignores do not mask lower-priority ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_done     <= 1'b0;
      r_blink    <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_tens <= w_pre_tens;
            r_ones <= w_pre_ones;
          end else if (w_start && !w_cnt_zero) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_pause) begin
            r_state <= ST_PAUSE;
          end else if (tick) begin
            if (w_last_count) begin
              r_ones     <= 4'd0;
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_blink    <= 1'b0;
              r_done_cnt <= '0;
            end else if (r_ones == 4'd0) begin
              r_ones <= BCD_MAX;
              r_tens <= r_tens - 4'd1;
            end else begin
              r_ones <= r_ones - 4'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (w_load) begin
            r_state <= ST_IDLE;
            r_tens  <= w_pre_tens;
            r_ones  <= w_pre_ones;
          end else if (w_pause || w_start) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (w_load || w_start || (tick && (r_done_cnt == DONE_LAST))) begin
            r_state <= ST_IDLE;
            r_tens  <= w_pre_tens;
            r_ones  <= w_pre_ones;
            r_done  <= 1'b0;
            r_blink <= 1'b0;
          end else if (tick) begin
            r_blink    <= ~r_blink;
            r_done_cnt <= r_done_cnt + DCW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Digit scan: on each scan_tick flip the selected digit and register its
  // value and anode pattern; anodes blank during the blink-off phase of DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel   <= 1'b0;
      r_digit <= 4'd0;
      r_an    <= AN_ONES;
    end else if (scan_tick) begin
      r_sel   <= ~r_sel;
      r_digit <= r_sel ? r_ones : r_tens;
      if ((r_state == ST_DONE) && r_blink)
        r_an <= AN_BLANK;
      else
        r_an <= r_sel ? AN_ONES : AN_TENS;
    end
  end

  assign digit    = r_digit;
  assign an       = r_an;
  assign cnt_tens = r_tens;
  assign cnt_ones = r_ones;
  assign state    = r_state;
  assign done     = r_done;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random stimulus, all
// checked each cycle against a count-as-integer behavioural model.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, scan_tick;
  logic       btn_start, btn_pause, btn_load;
  logic [3:0] preset_tens, preset_ones;
  logic [3:0] digit, cnt_tens, cnt_ones;
  logic [1:0] an, state;
  logic       done;

  countdown_ctrl #(.DONE_TICKS(5), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .scan_tick  (scan_tick),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_load   (btn_load),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .digit      (digit),
    .an         (an),
    .cnt_tens   (cnt_tens),
    .cnt_ones   (cnt_ones),
    .state      (state),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // stimulus held for the next clock edge
  bit       g_tick, g_scan;
  bit [2:0] g_btn;   // 0 start, 1 pause, 2 load
  int       g_pt, g_po;

  // model: state 0 IDLE 1 RUN 2 PAUSE 3 DONE, count as plain integer 0..99
  int m_state, m_cnt, m_blink, m_dcnt, m_sel, m_digit, m_an;
  bit [2:0] h1, h2, h3;  // raw buttons sampled 1, 2, 3 edges ago

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_blink = 0; m_dcnt = 0;
    m_sel = 0; m_digit = 0; m_an = 2;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  // Advance the model across one clock edge using the held stimulus.
  task automatic model_edge();
    bit s, p, l;
    int preset, os, oc, ob;
    s = h2[0] & ~h3[0];
    p = h2[1] & ~h3[1];
    l = h2[2] & ~h3[2];
    h3 = h2; h2 = h1; h1 = g_btn;
    preset = clamp9(g_pt) * 10 + clamp9(g_po);
    os = m_state; oc = m_cnt; ob = m_blink;
    if (g_scan) begin
      m_sel   = 1 - m_sel;
      m_digit = m_sel ? oc / 10 : oc % 10;
      m_an    = (os == 3 && ob == 1) ? 3 : (m_sel ? 1 : 2);
    end
    case (os)
      0: if (l) m_cnt = preset;
         else if (s && m_cnt != 0) m_state = 1;
      1: if (p) m_state = 2;
         else if (g_tick) begin
           if (m_cnt <= 1) begin m_cnt = 0; m_state = 3; m_dcnt = 0; m_blink = 0; end
           else m_cnt = m_cnt - 1;
         end
      2: if (l) begin m_state = 0; m_cnt = preset; end
         else if (p || s) m_state = 1;
      default: begin
        if (l || s || (g_tick && m_dcnt == 4)) begin
          m_state = 0; m_cnt = preset; m_blink = 0; m_dcnt = 0;
        end else if (g_tick) begin
          m_blink = 1 - m_blink; m_dcnt++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("state",    int'(state),    m_state);
    chk("cnt_tens", int'(cnt_tens), m_cnt / 10);
    chk("cnt_ones", int'(cnt_ones), m_cnt % 10);
    chk("done",     int'(done),     (m_state == 3) ? 1 : 0);
    chk("digit",    int'(digit),    m_digit);
    chk("an",       int'(an),       m_an);
  endtask

  // Called at a falling edge: drive, predict, clock, then compare.
  task automatic step();
    tick        = g_tick;
    scan_tick   = g_scan;
    btn_start   = g_btn[0];
    btn_pause   = g_btn[1];
    btn_load    = g_btn[2];
    preset_tens = 4'(g_pt);
    preset_ones = 4'(g_po);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int b, input int tick_at);
    for (int i = 1; i <= 6; i++) begin
      g_btn[b] = (i <= 4);
      g_tick   = (i == tick_at);
      step();
    end
    g_tick = 0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      g_tick = 1; step();
      g_tick = 0; step();
    end
  endtask

  task automatic scan_once();
    g_scan = 1; step();
    g_scan = 0; step();
  endtask

  initial begin
    reset = 1'b0;
    g_tick = 0; g_scan = 0; g_btn = '0; g_pt = 0; g_po = 0;
    tick = 0; scan_tick = 0; btn_start = 0; btn_pause = 0; btn_load = 0;
    preset_tens = 0; preset_ones = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_cnt",   int'({cnt_tens, cnt_ones}), 0);
    chk("rst_an",    int'(an), 2);
    chk("rst_digit", int'(digit), 0);
    chk("rst_done",  int'(done), 0);

    // load 12, run down to DONE, blink, and auto-return
    g_pt = 1; g_po = 2;
    press(2, 0);
    chk("load12_tens", int'(cnt_tens), 1);
    chk("load12_ones", int'(cnt_ones), 2);
    press(0, 0);
    chk("run_state", int'(state), 1);
    scan_once();
    tick_n(3);
    chk("cnt09_tens", int'(cnt_tens), 0);
    chk("cnt09_ones", int'(cnt_ones), 9);
    tick_n(9);
    chk("done_state", int'(state), 3);
    chk("done_flag",  int'(done), 1);
    chk("done_cnt",   int'({cnt_tens, cnt_ones}), 0);
    scan_once();
    scan_once();
    tick_n(1);
    scan_once();
    chk("blink_an", int'(an), 3);
    tick_n(4);
    chk("ret_state", int'(state), 0);
    chk("ret_cnt",   int'({cnt_tens, cnt_ones}), 8'h12);

    // pause pulse colliding with a tick
    g_pt = 2; g_po = 5;
    press(2, 0);
    press(0, 0);
    press(1, 3);
    chk("coll_state", int'(state), 2);
    chk("coll_cnt",   int'({cnt_tens, cnt_ones}), 8'h25);
    tick_n(3);
    chk("frozen_cnt", int'({cnt_tens, cnt_ones}), 8'h25);
    press(0, 0);
    chk("resume_state", int'(state), 1);
    tick_n(1);
    chk("resume_cnt", int'({cnt_tens, cnt_ones}), 8'h24);

    // clamp via PAUSE->load, then zero start ignored
    press(1, 0);
    g_pt = 15; g_po = 12;
    press(2, 0);
    chk("clamp_state", int'(state), 0);
    chk("clamp_cnt",   int'({cnt_tens, cnt_ones}), 8'h99);
    g_pt = 0; g_po = 0;
    press(2, 0);
    press(0, 0);
    chk("zero_start", int'(state), 0);

    // async reset mid-RUN at 37
    g_pt = 3; g_po = 7;
    press(2, 0);
    press(0, 0);
    chk("pre_rst_cnt", int'({cnt_tens, cnt_ones}), 8'h37);
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt",   int'({cnt_tens, cnt_ones}), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_an",    int'(an), 2);
    chk("arst_done",  int'(done), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // random phase
    for (int i = 0; i < 4000; i++) begin
      g_tick = ($urandom_range(0, 7) == 0);
      g_scan = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 15) == 0) g_btn[b] = ~g_btn[b];
      if ($urandom_range(0, 63) == 0) begin
        g_pt = $urandom_range(0, 15);
        g_po = $urandom_range(0, 15);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
